wtb_poly_synthesis: RTL

Polyphonic, parametrised successor to the single-voice wavetable synthesis path. It owns voice allocation (note on/off, retrigger, round-robin stealing) and one phase accumulator per voice. It also renders all voices time-multiplexed through one shared wavetable sample read port, and mixes the velocity-scaled voice samples into one output sample per sample_rate tick. It sits between the MIDI note decoder and the DAC/output stage. Wavetable loading and RAM are outside this block.

---
 rtl/wtb_poly_synthesis.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wtb_poly_synthesis.sv
// Polyphonic wavetable voice engine: note allocation with retrigger/steal, per-voice
// phase accumulators, one shared time-multiplexed wavetable read port and a voice mixer.
module wtb_poly_synthesis #(
  parameter int VOICES   = 4,
  parameter int PHASE_W  = 16,
  parameter int IDX_W    = 7,
  parameter int SAMPLE_W = 8,
  parameter int MIX_MODE = 0,
  localparam int VB      = $clog2(VOICES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_rate,
  output logic                note_ready,
  input  logic                note_on,
  input  logic                note_off,
  input  logic [6:0]          note_num,
  input  logic [6:0]          note_vel,
  input  logic [PHASE_W-1:0]  note_inc,
  input  logic [5:0]          note_prog,
  output logic                note_ack,
  output logic [VB-1:0]       voice_idx,
  output logic [VOICES-1:0]   active,
  output logic                wav_re,
  output logic [5:0]          wav_prog,
  output logic [IDX_W-1:0]    wav_idx,
  input  logic [SAMPLE_W-1:0] wav_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_dv,
  output logic                overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RENDER, S_DRAIN} state_t;

  localparam int ACC_W = SAMPLE_W + VB;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << SAMPLE_W) - 1);
  localparam logic [VB-1:0]    LAST_SLOT = VB'(VOICES - 1);

  state_t r_state, w_next;

  logic [VOICES-1:0]  r_active;
  logic [PHASE_W-1:0] r_phase [VOICES];
  logic [PHASE_W-1:0] r_inc   [VOICES];
  logic [6:0]         r_vel   [VOICES];
  logic [6:0]         r_note  [VOICES];
  logic [5:0]         r_prog  [VOICES];
  logic [VB-1:0]      r_steal;
  logic [VB-1:0]      r_slot;
  logic [VB-1:0]      r_voice_idx;
  logic               r_note_ack;

  logic               r_p1_vld, r_p1_act, r_p1_last;
  logic [6:0]         r_p1_vel;
  logic               r_p2_vld, r_p2_last;
  logic [SAMPLE_W-1:0] r_scaled;
  logic [ACC_W-1:0]   r_acc;
  logic [SAMPLE_W-1:0] r_sample_out;
  logic               r_sample_dv;

  logic               w_ready, w_on, w_off, w_rd, w_start;
  logic               w_hit, w_free, w_steal;
  logic [VB-1:0]      w_hit_idx, w_free_idx, w_sel;
  logic [SAMPLE_W+6:0] w_prod;
  logic [SAMPLE_W-1:0] w_scaled;
  logic [ACC_W-1:0]   w_acc_next;
  logic [SAMPLE_W-1:0] w_mix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (sample_rate) w_next = S_RENDER;
      S_RENDER: if (r_slot == LAST_SLOT) w_next = S_DRAIN;
      S_DRAIN:  if (r_sample_dv) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the current render slot
  always_comb begin
    w_ready  = (r_state == S_IDLE) && !sample_rate;
    w_start  = (r_state == S_IDLE) && sample_rate;
    overrun  = sample_rate && (r_state != S_IDLE);
    w_rd     = (r_state == S_RENDER) && r_active[r_slot];
    wav_re   = w_rd;
    wav_prog = '0;
    wav_idx  = '0;
    if (w_rd) begin
      wav_prog = r_prog[r_slot];
      wav_idx  = IDX_W'(r_phase[r_slot] >> (PHASE_W - IDX_W));
    end
  end

  // Voice lookup: lowest-index held match and lowest-index free voice
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = VOICES; i > 0; i--) begin
      if (r_active[i-1] && (r_note[i-1] == note_num)) begin
        w_hit     = 1'b1;
        w_hit_idx = VB'(i - 1);
      end
      if (!r_active[i-1]) begin
        w_free     = 1'b1;
        w_free_idx = VB'(i - 1);
      end
    end
    w_on    = note_on && w_ready;
    w_off   = note_off && w_ready && !note_on;
    w_steal = !w_hit && !w_free;
    w_sel   = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_steal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= '0;
      r_steal     <= '0;
      r_voice_idx <= '0;
      r_note_ack  <= 1'b0;
      r_slot      <= '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        r_phase[i] <= '0;
        r_inc[i]   <= '0;
        r_vel[i]   <= '0;
        r_note[i]  <= '0;
        r_prog[i]  <= '0;
      end
    end else begin
      r_note_ack <= w_on;
      r_slot     <= (r_state == S_RENDER) ? r_slot + 1'b1 : '0;
      if (w_on) begin
        r_active[w_sel] <= 1'b1;
        r_phase[w_sel]  <= '0;
        r_inc[w_sel]    <= note_inc;
        r_vel[w_sel]    <= note_vel;
        r_note[w_sel]   <= note_num;
        r_prog[w_sel]   <= note_prog;
        r_voice_idx     <= w_sel;
        if (w_steal) r_steal <= r_steal + 1'b1;
      end else if (w_off && w_hit) begin
        r_active[w_hit_idx] <= 1'b0;
      end
      // Notes are only accepted in IDLE, so this never races the note load above
      if (w_rd) r_phase[r_slot] <= r_phase[r_slot] + r_inc[r_slot];
    end
  end

  always_comb begin
    w_prod     = wav_data * r_p1_vel;
    w_scaled   = SAMPLE_W'(w_prod >> 7);
    w_acc_next = r_acc + ACC_W'(r_scaled);
    if (MIX_MODE == 0) begin
      w_mix = SAMPLE_W'(w_acc_next >> VB);
    end else begin
      w_mix = (w_acc_next > SAT_MAX) ? '1 : SAMPLE_W'(w_acc_next);
    end
  end

  // Read -> scale -> accumulate pipeline; the final add feeds the mixer directly
  // so sample_dv lands VOICES+3 cycles after the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_vld     <= 1'b0;
      r_p1_act     <= 1'b0;
      r_p1_last    <= 1'b0;
      r_p1_vel     <= '0;
      r_p2_vld     <= 1'b0;
      r_p2_last    <= 1'b0;
      r_scaled     <= '0;
      r_acc        <= '0;
      r_sample_out <= '0;
      r_sample_dv  <= 1'b0;
    end else begin
      r_p1_vld    <= (r_state == S_RENDER);
      r_p1_act    <= w_rd;
      r_p1_last   <= (r_state == S_RENDER) && (r_slot == LAST_SLOT);
      r_p1_vel    <= r_vel[r_slot];
      r_p2_vld    <= r_p1_vld;
      r_p2_last   <= r_p1_last;
      r_scaled    <= r_p1_act ? w_scaled : '0;
      r_sample_dv <= r_p2_vld && r_p2_last;
      if (w_start) begin
        r_acc <= '0;
      end else if (r_p2_vld) begin
        r_acc <= w_acc_next;
      end
      if (r_p2_vld && r_p2_last) r_sample_out <= w_mix;
    end
  end

  assign note_ready = w_ready;
  assign note_ack   = r_note_ack;
  assign voice_idx  = r_voice_idx;
  assign active     = r_active;
  assign sample_out = r_sample_out;
  assign sample_dv  = r_sample_dv;

endmodule
